delay_valid_n: RTL and testbench
================================

# delay_valid_n

Parametrised, valid-tagged, multi-lane delay line that aligns operand streams between processing-element pipeline stages in the polynomial-arithmetic datapath. It is the successor of the fixed-depth delay line. It adds per-beat valid tracking, a global stall enable, a one-cycle flush, a runtime-selectable tap depth, and in-flight occupancy reporting.

## Interface
Parameters:
- DWIDTH, 12, bits per lane
- LANES, 1, parallel lanes sharing one valid/enable/flush control
- MAX_DEPTH, 3, number of register stages built (≥1)
- DEPTH_W, $clog2(MAX_DEPTH+1), width of depth_i and count_o (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously to clk
- en_i  in  1  shift enable; 0 = whole line stalls
- flush_i  in  1  invalidate all in-flight beats
- valid_i  in  1  data_i carries a beat
- data_i  in  LANES*DWIDTH  input beat, lane k at bits [k*DWIDTH +: DWIDTH]
- depth_i  in  DEPTH_W  selected delay in enabled cycles
- valid_o  out  1  valid bit at selected tap
- data_o  out  LANES*DWIDTH  data at selected tap
- count_o  out  DEPTH_W  valid beats held in stages 1..eff_depth
- empty_o  out  1  count_o == 0

## Operation
- Storage: stage[1..MAX_DEPTH], each holding LANES*DWIDTH data plus 1 valid bit.
- eff_depth = depth_i if 1 ≤ depth_i ≤ MAX_DEPTH, otherwise MAX_DEPTH (0 and out-of-range values clamp to MAX_DEPTH).
- Per edge, priority order:
  1. Reset: all data and valid bits go to 0.
  2. flush_i=1: all valid bits go to 0 regardless of en_i. Data registers hold. The beat presented that cycle is dropped.
  3. en_i=1: stage[1] ← {valid_i, data_i}; stage[k] ← stage[k-1].
  4. en_i=0: all stages hold. Input is ignored.
- Outputs are combinational muxes off registers only. There is no path from data_i to any output.
  - data_o = stage[eff_depth].data; valid_o = stage[eff_depth].valid.
- count_o = popcount of valid bits in stage[1..eff_depth]. Beats beyond eff_depth are not counted.
- Data moves whether or not it is valid. Invalid beats (bubbles) occupy slots and preserve spacing.
- depth_i may change at any time; the output simply follows the new tap. Beats may be skipped or repeated unless the change is made while empty_o=1. Users must change depth only when empty.

## Timing
- Reset values: valid_o=0, data_o=0, count_o=0, empty_o=1. These hold from rst assertion with no clock required.
- Latency: a beat sampled on edge N appears on data_o/valid_o after edge N+eff_depth−1, i.e. eff_depth enabled edges after sampling. Each stalled edge adds one cycle.
- Throughput: one beat per enabled cycle, with no back-pressure output.
- Flush: valid_o=0 and count_o=0 from the edge after the flush cycle. Beats sampled after the flush emerge at normal latency.
- Simultaneous flush_i and en_i: flush wins; data still shifts in but is marked invalid.
- Reset mid-stream discards all in-flight beats.

## Structure
- Package delay_pkg holds:
  - function clamp_depth(depth, max) returning eff_depth
  - popcount helper
  - lane-slicing localparam convention.
- Sub-module delay_stage: a single register stage (LANES*DWIDTH data + valid) with en, flush and async active-low reset. delay_valid_n instantiates MAX_DEPTH of them in a generate loop and adds the tap mux and occupancy logic.

## Test plan
- Reset: pulse rst low mid-stream with 2 beats in flight → valid_o, data_o, count_o go to 0 and empty_o to 1 immediately, with no clock edge.
- Streaming (LANES=2, MAX_DEPTH=4, depth_i=3): drive continuous valid beats {0x001,0x801}..{0x014,0x814} → each appears with valid_o=1 exactly 3 edges after sampling; no gaps; count_o=3 in steady state.
- Stall: in the same stream, hold en_i=0 for 2 cycles after beat 0x005 → outputs and count_o freeze. 0x005 emerges 5 edges after sampling. No beat is lost or duplicated.
- Flush: with 3 beats in flight, assert flush_i and en_i with valid_i=1, data 0x0AA for one cycle.
  - 0x0AA is never flagged valid.
  - valid_o=0 and count_o=0 from the next edge.
  - A following beat 0x0BB appears at 3-cycle latency.
- Depth sweep: for depth_i=1..4, each set while empty, send a single beat 0xABC → valid_o pulses exactly depth_i edges later. depth_i=0 and depth_i=7 both behave as 4.
- Bubbles: drive valid_i pattern 1,0,1,1,0 at depth 3 → valid_o reproduces the pattern 3 edges later; count_o follows the popcount of the last 3 sampled valid bits (1,1,2,2,2).

Source files
------------

// File: rtl/delay_pkg.sv
// Shared helpers for the valid-tagged delay line: tap clamping, occupancy
// popcount and the lane-slicing convention for packed multi-lane beats.
package delay_pkg;

  // Widest valid vector the popcount helper accepts; callers zero-extend.
  localparam int POP_W = 64;

  // Lane k of a packed beat lives at bits [k*DWIDTH +: DWIDTH].
  function automatic int lane_lsb(int lane, int dwidth);
    return lane * dwidth;
  endfunction

  // 0 and anything above max_depth select the deepest tap.
  function automatic int clamp_depth(int depth, int max_depth);
    if (depth >= 1 && depth <= max_depth) begin
      return depth;
    end
    return max_depth;
  endfunction

  function automatic int popcount(logic [POP_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line: a packed multi-lane data word plus
// its valid bit, with shift enable, valid flush and async active-low reset.
module delay_stage #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // Data follows en alone so a flushed-and-enabled cycle still shifts the
  // word in; flush only kills the valid bit, and does so even when stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (en) begin
        data_q <= data_d;
      end
      if (flush) begin
        valid_q <= 1'b0;
      end else if (en) begin
        valid_q <= valid_d;
      end
    end
  end

endmodule

// File: rtl/delay_valid_n.sv
// Valid-tagged multi-lane delay line with stall, flush, runtime tap select
// and occupancy count over the stages up to the selected tap.
module delay_valid_n #(
  parameter int DWIDTH    = 12,
  parameter int LANES     = 1,
  parameter int MAX_DEPTH = 3,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [LANES*DWIDTH-1:0] data_i,
  input  logic [DEPTH_W-1:0]      depth_i,
  output logic                    valid_o,
  output logic [LANES*DWIDTH-1:0] data_o,
  output logic [DEPTH_W-1:0]      count_o,
  output logic                    empty_o
);

  import delay_pkg::*;

  localparam int W = LANES * DWIDTH;

  // valid_i qualifies data_i for one enabled cycle; there is no ready, the
  // line accepts one beat per enabled cycle and bubbles keep their slot.
  logic [W-1:0]       data_s [MAX_DEPTH+1];
  logic [MAX_DEPTH:0] valid_s;
  logic [POP_W-1:0]   occ_vec;
  int                 eff_depth;

  assign data_s[0]  = data_i;
  assign valid_s[0] = valid_i;

  for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
    delay_stage #(
      .W (W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en_i),
      .flush   (flush_i),
      .valid_d (valid_s[k-1]),
      .data_d  (data_s[k-1]),
      .valid_q (valid_s[k]),
      .data_q  (data_s[k])
    );
  end

  // Outputs come only from stage registers, never from data_i directly.
  always_comb begin
    eff_depth = clamp_depth(int'(depth_i), MAX_DEPTH);
    valid_o   = 1'b0;
    data_o    = '0;
    occ_vec   = '0;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (k == eff_depth) begin
        valid_o = valid_s[k];
        data_o  = data_s[k];
      end
      if (k <= eff_depth) begin
        occ_vec[k-1] = valid_s[k];
      end
    end
    count_o = DEPTH_W'(popcount(occ_vec));
  end

  assign empty_o = (count_o == '0);

endmodule

// File: tb/tb_delay_valid_n.sv
// Directed bench for delay_valid_n with LANES=2, MAX_DEPTH=4.
module tb_delay_valid_n;

  localparam int DW = 12;
  localparam int LN = 2;
  localparam int MD = 4;
  localparam int DEPTH_W = 3;
  localparam int W = DW * LN;

  logic               clk;
  logic               rst;
  logic               en_i;
  logic               flush_i;
  logic               valid_i;
  logic [W-1:0]       data_i;
  logic [DEPTH_W-1:0] depth_i;
  logic               valid_o;
  logic [W-1:0]       data_o;
  logic [DEPTH_W-1:0] count_o;
  logic               empty_o;

  int n_cmp;
  int n_err;

  typedef struct {
    logic         en;
    logic         flush;
    logic         valid;
    logic [W-1:0] data;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic [2:0]   exp_count;
    logic         chk_data;
  } vec_t;

  vec_t tbl [19];

  delay_valid_n #(
    .DWIDTH    (DW),
    .LANES     (LN),
    .MAX_DEPTH (MD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .depth_i (depth_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .count_o (count_o),
    .empty_o (empty_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] beat(int n);
    logic [DW-1:0] lo;
    lo = DW'(n);
    return {12'h800 | lo, lo};
  endfunction

  function automatic vec_t mk(logic en, logic fl, logic v, logic [W-1:0] d,
                              logic ev, logic [W-1:0] ed, logic [2:0] ec, logic cd);
    vec_t r;
    r.en = en; r.flush = fl; r.valid = v; r.data = d;
    r.exp_valid = ev; r.exp_data = ed; r.exp_count = ec; r.chk_data = cd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // driver: apply inputs, take one edge, sample 1 time unit later
  task automatic tick(input logic en, input logic fl, input logic v, input logic [W-1:0] d);
    en_i = en; flush_i = fl; valid_i = v; data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [2:0] ec);
    chk({tag, ".valid"}, 32'(valid_o), 32'(ev));
    chk({tag, ".count"}, 32'(count_o), 32'(ec));
    chk({tag, ".empty"}, 32'(empty_o), 32'(ec == 3'd0));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
    depth_i = 3'd3;

    // reset state
    #12;
    chk_out("reset", 1'b0, 3'd0);
    chk("reset.data", 32'(data_o), 32'h0);
    rst = 1'b1;

    // streaming at depth 3 with a 2-cycle stall after beat 5
    for (int n = 1; n <= 20; n++) begin
      tick(1'b1, 1'b0, 1'b1, beat(n));
      chk_out($sformatf("stream%0d", n), n >= 3, (n < 3) ? 3'(n) : 3'd3);
      if (n >= 3) chk($sformatf("stream%0d.data", n), 32'(data_o), 32'(beat(n - 2)));
      if (n == 5) begin
        for (int s = 0; s < 2; s++) begin
          tick(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
          chk_out($sformatf("stall%0d", s), 1'b1, 3'd3);
          chk($sformatf("stall%0d.data", s), 32'(data_o), 32'(beat(3)));
        end
      end
    end

    // flush, bubbles and stalled flush, all at depth 3
    tbl[0]  = mk(1, 1, 1, 24'h0AA0AA, 0, '0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 24'h0BB0BB, 0, '0, 1, 0);
    tbl[2]  = mk(1, 0, 0, '0,         0, '0, 1, 0);
    tbl[3]  = mk(1, 0, 0, '0,         1, 24'h0BB0BB, 1, 1);
    tbl[4]  = mk(1, 0, 0, '0,         0, '0, 0, 0);
    tbl[5]  = mk(1, 0, 1, beat(8'h31), 0, '0, 1, 0);
    tbl[6]  = mk(1, 0, 0, beat(8'h32), 0, '0, 1, 0);
    tbl[7]  = mk(1, 0, 1, beat(8'h33), 1, beat(8'h31), 2, 1);
    tbl[8]  = mk(1, 0, 1, beat(8'h34), 0, '0, 2, 0);
    tbl[9]  = mk(1, 0, 0, beat(8'h35), 1, beat(8'h33), 2, 1);
    tbl[10] = mk(1, 0, 0, '0,          1, beat(8'h34), 1, 1);
    tbl[11] = mk(1, 0, 0, '0,          0, '0, 0, 0);
    tbl[12] = mk(1, 0, 0, '0,          0, '0, 0, 0);
    tbl[13] = mk(1, 0, 1, beat(8'h41), 0, '0, 1, 0);
    tbl[14] = mk(1, 0, 1, beat(8'h42), 0, '0, 2, 0);
    tbl[15] = mk(0, 0, 1, beat(8'h99), 0, '0, 2, 0);
    tbl[16] = mk(0, 1, 1, beat(8'h43), 0, '0, 0, 0);
    tbl[17] = mk(1, 0, 0, '0,          0, '0, 0, 0);
    tbl[18] = mk(1, 0, 0, '0,          0, '0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].en, tbl[i].flush, tbl[i].valid, tbl[i].data);
      chk_out($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_count);
      if (tbl[i].chk_data) chk($sformatf("tbl%0d.data", i), 32'(data_o), 32'(tbl[i].exp_data));
    end

    // depth sweep: 0 and 7 clamp to 4
    for (int t = 0; t < 6; t++) begin
      int d;
      int eff;
      d = (t < 4) ? t + 1 : ((t == 4) ? 0 : 7);
      eff = (d >= 1 && d <= 4) ? d : 4;
      for (int i = 0; i < MD; i++) tick(1'b1, 1'b0, 1'b0, '0);
      depth_i = 3'(d);
      for (int j = 1; j <= 5; j++) begin
        if (j == 1) tick(1'b1, 1'b0, 1'b1, 24'hABCABC);
        else        tick(1'b1, 1'b0, 1'b0, '0);
        chk_out($sformatf("depth%0d.j%0d", d, j), j == eff, (j <= eff) ? 3'd1 : 3'd0);
        if (j == eff) chk($sformatf("depth%0d.data", d), 32'(data_o), 32'h00ABCABC);
      end
    end

    // asynchronous reset with two beats in flight at depth 2
    depth_i = 3'd2;
    for (int i = 0; i < MD; i++) tick(1'b1, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b1, beat(8'h51));
    tick(1'b1, 1'b0, 1'b1, beat(8'h52));
    chk_out("pre_rst", 1'b1, 3'd2);
    chk("pre_rst.data", 32'(data_o), 32'(beat(8'h51)));
    #3;
    rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 3'd0);
    chk("async_rst.data", 32'(data_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1'b1, 1'b0, 1'b0, '0);
    chk_out("post_rst", 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
